// File: rtl/icache_downstream_responder.sv
// L2/memory stand-in below the icache MSHR: buffers line-fill requests in order and answers
// each with a full synthetic cache line after a fixed latency.
module icache_downstream_responder #(
  parameter int          REQ_FIFO_DEPTH = 4,
  parameter int          RESP_LATENCY   = 8,
  parameter logic [31:0] DATA_SEED      = 32'h0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           downstream_txreq_vld,
  output logic           downstream_txreq_rdy,
  input  logic [40:0]    downstream_txreq_pld,
  output logic           downstream_rxdat_vld,
  input  logic           downstream_rxdat_rdy,
  output logic [268:0]   downstream_rxdat_pld
);

  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [PTR_W:0] PTR_ONE    = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [40:0]      mem [REQ_FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr, count;
  logic             full, empty, push, pop, remain;
  logic [40:0]      head;

  // Line data: each word is its own byte address within the aligned line, scrambled by the seed.
  function automatic logic [255:0] line_data(input logic [31:0] addr);
    logic [31:0]  base;
    logic [255:0] data;
    base = addr & ~32'h1F;
    for (int i = 0; i < 8; i++) begin
      data[32*i +: 32] = (base + 32'(4*i)) ^ DATA_SEED;
    end
    return data;
  endfunction

  // Extra MSB on the pointers distinguishes full from empty when the indices match.
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push   = downstream_txreq_vld && !full;
  assign pop    = (state == S_RESP) && downstream_rxdat_rdy;
  assign remain = (count > PTR_ONE) || push;
  assign head   = mem[rd_ptr[PTR_W-1:0]];

  assign downstream_txreq_rdy = !full;
  assign downstream_rxdat_vld = (state == S_RESP);
  assign downstream_rxdat_pld = (state == S_RESP)
    ? {head[40:36], head[35:32], line_data(head[31:0]), head[35:32]}
    : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= downstream_txreq_pld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      S_RESP: begin
        if (downstream_rxdat_rdy) begin
          if (remain) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_downstream_responder.sv
// Scoreboard bench for icache_downstream_responder: directed scenarios plus random traffic,
// checked at the falling edge against a queue-based reference of order, timing and line data.
module tb_icache_downstream_responder;

  localparam int          DEPTH = 4;
  localparam int          LAT   = 8;
  localparam logic [31:0] SEED  = 32'h5A5A_C3C3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         txreq_vld;
  logic         txreq_rdy;
  logic [40:0]  txreq_pld;
  logic         rxdat_vld;
  logic         rxdat_rdy;
  logic [268:0] rxdat_pld;

  icache_downstream_responder #(
    .REQ_FIFO_DEPTH(DEPTH), .RESP_LATENCY(LAT), .DATA_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .downstream_txreq_vld(txreq_vld), .downstream_txreq_rdy(txreq_rdy),
    .downstream_txreq_pld(txreq_pld),
    .downstream_rxdat_vld(rxdat_vld), .downstream_rxdat_rdy(rxdat_rdy),
    .downstream_rxdat_pld(rxdat_pld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [268:0] pld;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           last_pop = -1000;
  logic [268:0] held_pld;
  bit           held_ok = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [268:0] act, input logic [268:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference response: fields echoed, line aligned by dropping the offset, words by byte address.
  function automatic logic [268:0] model(input logic [40:0] req);
    logic [31:0]  a, base;
    logic [255:0] d;
    a    = req[31:0];
    base = a - (a % 32);
    for (int i = 0; i < 8; i++) d[32*i +: 32] = (base + 32'(4*i)) ^ SEED;
    return {req[40:36], req[35:32], d, req[35:32]};
  endfunction

  // Monitor: a request accepted at edge a is served once it reaches the head; its response is
  // valid LAT edges after the previous pop if it was already queued then, else LAT+1 after a.
  always @(negedge clk) begin
    exp_t e;
    int   due;
    bit   exp_vld;
    if (!rst_n) begin
      chk(rxdat_vld == 1'b0, "rst_vld", 269'(rxdat_vld), 269'(0));
      chk(txreq_rdy == 1'b1, "rst_rdy", 269'(txreq_rdy), 269'(1));
      chk(rxdat_pld == '0, "rst_pld", rxdat_pld, '0);
      q.delete();
      last_pop = -1000;
      held_ok  = 0;
    end else begin
      exp_vld = 1'b0;
      if (q.size() > 0) begin
        due     = (q[0].acc <= last_pop) ? last_pop + LAT : q[0].acc + 1 + LAT;
        exp_vld = (cyc >= due);
      end
      chk(rxdat_vld == exp_vld, "rxdat_vld", 269'(rxdat_vld), 269'(exp_vld));
      chk(txreq_rdy == (q.size() < DEPTH), "txreq_rdy", 269'(txreq_rdy), 269'(q.size() < DEPTH));
      if (rxdat_vld && held_ok) chk(rxdat_pld == held_pld, "pld_stable", rxdat_pld, held_pld);
      if (rxdat_vld) begin
        held_pld = rxdat_pld;
        held_ok  = 1;
      end
      if (rxdat_vld && rxdat_rdy) begin
        if (q.size() > 0) begin
          chk(rxdat_pld == q[0].pld, "resp_pld", rxdat_pld, q[0].pld);
          void'(q.pop_front());
        end else begin
          chk(1'b0, "resp_unexpected", rxdat_pld, '0);
        end
        last_pop = cyc + 1;
        held_ok  = 0;
      end
      if (txreq_vld && txreq_rdy) begin
        e.pld = model(txreq_pld);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [3:0] id, input logic [31:0] a);
    txreq_vld = 1'b1;
    txreq_pld = {op, id, a};
    tick();
    txreq_vld = 1'b0;
  endtask

  task automatic wait_vld(input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (rxdat_vld) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk(1'b0, name, 269'(0), 269'(1));
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    rxdat_rdy = 1'b1;
    txreq_vld = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !rxdat_vld) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk(1'b0, name, 269'(q.size()), 269'(0));
  endtask

  task automatic check_line(input string name, input logic [31:0] w0, input logic [31:0] w7,
                            input logic [3:0] id, input logic [4:0] op);
    chk(rxdat_pld[35:4] == (w0 ^ SEED), {name, "_word0"}, 269'(rxdat_pld[35:4]), 269'(w0 ^ SEED));
    chk(rxdat_pld[259:228] == (w7 ^ SEED), {name, "_word7"}, 269'(rxdat_pld[259:228]), 269'(w7 ^ SEED));
    chk(rxdat_pld[263:260] == id, {name, "_txnid"}, 269'(rxdat_pld[263:260]), 269'(id));
    chk(rxdat_pld[3:0] == id, {name, "_entry"}, 269'(rxdat_pld[3:0]), 269'(id));
    chk(rxdat_pld[268:264] == op, {name, "_opcode"}, 269'(rxdat_pld[268:264]), 269'(op));
  endtask

  initial begin
    bit acc;
    rst_n     = 1'b0;
    txreq_vld = 1'b0;
    txreq_pld = '0;
    rxdat_rdy = 1'b0;
    tick();
    tick();
    chk(rxdat_vld == 1'b0 && txreq_rdy == 1'b1, "reset_outputs", 269'({rxdat_vld, txreq_rdy}), 269'(2'b01));
    rst_n = 1'b1;
    tick();

    // Single request, fixed timing and field echo.
    rxdat_rdy = 1'b1;
    send(5'd1, 4'd3, 32'h0000_1240);
    wait_vld("s1_timeout");
    check_line("s1", 32'h0000_1240, 32'h0000_125C, 4'd3, 5'd1);
    drain("s1_drain");

    // Offset ignored; top-of-memory line.
    send(5'd2, 4'd5, 32'h0000_1244);
    wait_vld("s2a_timeout");
    check_line("s2a", 32'h0000_1240, 32'h0000_125C, 4'd5, 5'd2);
    drain("s2a_drain");
    send(5'd31, 4'd15, 32'hFFFF_FFE0);
    wait_vld("s2b_timeout");
    check_line("s2b", 32'hFFFF_FFE0, 32'hFFFF_FFFC, 4'd15, 5'd31);
    drain("s2b_drain");

    // Fill the buffer with responses blocked; fifth request stalls.
    rxdat_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(5'd4, 4'(i), 32'h0001_0000 + 32'(i * 32));
    chk(txreq_rdy == 1'b0, "s3_full_rdy", 269'(txreq_rdy), 269'(0));
    txreq_vld = 1'b1;
    txreq_pld = {5'd4, 4'd4, 32'h0001_0080};
    for (int i = 0; i < 3; i++) tick();
    chk(txreq_rdy == 1'b0, "s3_stall_rdy", 269'(txreq_rdy), 269'(0));
    rxdat_rdy = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (txreq_rdy) begin
        acc = 1;
        tick();
        break;
      end
      tick();
    end
    txreq_vld = 1'b0;
    if (!acc) chk(1'b0, "s3_fifth_accept", 269'(0), 269'(1));
    drain("s3_drain");

    // Response held under backpressure.
    rxdat_rdy = 1'b0;
    send(5'd6, 4'd9, 32'h00AB_CDE4);
    wait_vld("s4_timeout");
    for (int i = 0; i < 5; i++) tick();
    chk(rxdat_vld == 1'b1, "s4_held_vld", 269'(rxdat_vld), 269'(1));
    rxdat_rdy = 1'b1;
    tick();
    chk(rxdat_vld == 1'b0, "s4_popped", 269'(rxdat_vld), 269'(0));

    // Push coinciding with the pop of the only entry.
    send(5'd7, 4'd1, 32'h2000_0000);
    wait_vld("s5_timeout");
    send(5'd8, 4'd2, 32'h2000_0020);
    drain("s5_drain");

    // Reset while waiting with two entries buffered.
    rxdat_rdy = 1'b0;
    send(5'd9, 4'd6, 32'h3000_0000);
    send(5'd9, 4'd7, 32'h3000_0020);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk(rxdat_vld == 1'b0, "s6_rst_vld", 269'(rxdat_vld), 269'(0));
    chk(txreq_rdy == 1'b1, "s6_rst_rdy", 269'(txreq_rdy), 269'(1));
    tick();
    tick();
    rst_n     = 1'b1;
    rxdat_rdy = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      txreq_vld = ($urandom_range(0, 1) == 1);
      txreq_pld = {5'($urandom), 4'($urandom), 32'($urandom)};
      rxdat_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
